hamming_decoder: RTL and testbench

Pipelined Hamming [7,4] decoder that receives 7-bit codewords produced by the team's Hamming encoder, corrects any single-bit error, and returns the 4 data bits. It uses valid/ready handshakes on both sides and sits on the receive side of the link, after the channel or storage element and before the data consumer. Optional saturating statistics counters report traffic and corrected-error counts.

---
 rtl/hamming_decoder.sv | 161 ++++++++++++++++
 tb/tb_hamming_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// hamming_decoder: two-stage pipelined Hamming [7,4] decoder with valid/ready
// handshakes on both sides. Stage 1 holds the received codeword and its
// syndrome; stage 2 holds the corrected data and error flags.
// Optional saturating traffic/error counters are built when the macro
// HAMMING_DEC_STATS_EN is defined; otherwise the counter outputs are tied to 0.
module hamming_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_codeword,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_err,
    output logic [2:0]       out_err_pos,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count
);

    logic       stall;
    logic [2:0] in_syn;

    logic       s1_valid_q, s1_valid_d;
    logic [6:0] s1_cw_q, s1_cw_d;
    logic [2:0] s1_syn_q, s1_syn_d;

    logic       out_valid_q, out_valid_d;
    logic [3:0] out_data_q, out_data_d;
    logic       out_err_q, out_err_d;
    logic [2:0] out_err_pos_q, out_err_pos_d;

    logic [2:0] flip_pos;
    logic [3:0] data_flip_mask;

    // A result that is presented but not taken freezes the whole pipeline.
    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    // Each syndrome bit re-checks one parity equation over the received word.
    assign in_syn = {in_codeword[2] ^ in_codeword[6] ^ in_codeword[5] ^ in_codeword[4],
                     in_codeword[1] ^ in_codeword[5] ^ in_codeword[4] ^ in_codeword[3],
                     in_codeword[0] ^ in_codeword[6] ^ in_codeword[5] ^ in_codeword[3]};

    // Map the stage-1 syndrome to the flipped bit index; only data bits need a mask.
    always_comb begin
        flip_pos       = 3'd0;
        data_flip_mask = 4'b0000;
        case (s1_syn_q)
            3'b101: begin flip_pos = 3'd6; data_flip_mask = 4'b1000; end
            3'b111: begin flip_pos = 3'd5; data_flip_mask = 4'b0100; end
            3'b110: begin flip_pos = 3'd4; data_flip_mask = 4'b0010; end
            3'b011: begin flip_pos = 3'd3; data_flip_mask = 4'b0001; end
            3'b100: flip_pos = 3'd2;
            3'b010: flip_pos = 3'd1;
            3'b001: flip_pos = 3'd0;
            default: ;
        endcase
    end

    // Both stages advance together unless stalled; empty slots carry zeros.
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_cw_d       = s1_cw_q;
        s1_syn_d      = s1_syn_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_err_d     = out_err_q;
        out_err_pos_d = out_err_pos_q;
        if (!stall) begin
            s1_valid_d  = in_valid;
            s1_cw_d     = in_valid ? in_codeword : 7'd0;
            s1_syn_d    = in_valid ? in_syn : 3'd0;
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d    = s1_cw_q[6:3] ^ data_flip_mask;
                out_err_d     = (s1_syn_q != 3'd0);
                out_err_pos_d = flip_pos;
            end else begin
                out_data_d    = 4'd0;
                out_err_d     = 1'b0;
                out_err_pos_d = 3'd0;
            end
        end
    end

    // Pipeline registers; reset empties both stages so nothing in flight escapes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_cw_q       <= 7'd0;
            s1_syn_q      <= 3'd0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 4'd0;
            out_err_q     <= 1'b0;
            out_err_pos_q <= 3'd0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_cw_q       <= s1_cw_d;
            s1_syn_q      <= s1_syn_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_err_q     <= out_err_d;
            out_err_pos_q <= out_err_pos_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_err     = out_err_q;
    assign out_err_pos = out_err_pos_q;

`ifdef HAMMING_DEC_STATS_EN
    logic             deliver;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign deliver = out_valid_q && out_ready;

    // Saturating counters bumped on each delivered word; clear wins over a bump.
    always_comb begin
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (stats_clr) begin
            word_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (deliver) begin
            if (word_cnt_q != '1) begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
            end
            if (out_err_q && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign word_count = word_cnt_q;
    assign err_count  = err_cnt_q;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr;
    assign word_count       = '0;
    assign err_count        = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// tb_hamming_decoder: randomized and directed stimulus with a queue-based
// scoreboard. The stimulus side encodes data with the parity equations and
// injects a known single-bit error, so the expected result is simply the
// original data plus the injected position. A negedge monitor pops and
// compares every delivered word and tracks the statistics counters.
module tb_hamming_decoder;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAMMING_DEC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [3:0] data;
        logic       err;
        logic [2:0] pos;
        int         cyc;
        bit         strict;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_codeword = 7'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_data;
    logic             out_err;
    logic [2:0]       out_err_pos;
    logic             stats_clr = 1'b0;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] err_count;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   strict_lat = 1'b0;
    int   wc_m = 0;
    int   ec_m = 0;
    bit   hold_prev = 1'b0;
    logic [3:0] prev_data;
    logic       prev_err;
    logic [2:0] prev_pos;

    hamming_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_codeword(in_codeword),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_err(out_err),
        .out_err_pos(out_err_pos),
        .stats_clr(stats_clr),
        .word_count(word_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] encode(input logic [3:0] d);
        return {d, d[3] ^ d[2] ^ d[1], d[2] ^ d[1] ^ d[0], d[3] ^ d[2] ^ d[0]};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus; e in 0..6 flips that codeword bit, 7 means clean.
    task automatic applyStimulus(input bit v, input logic [3:0] d, input int e,
                                 input bit rdy, input bit clr);
        logic [6:0] cw;
        exp_t       x;
        cw = encode(d);
        if (e < 7) cw[e] = ~cw[e];
        @(posedge clk);
        #1;
        in_valid    = v;
        in_codeword = cw;
        out_ready   = rdy;
        stats_clr   = clr;
        @(negedge clk);
        if (v && in_ready && !rst) begin
            x.data   = d;
            x.err    = (e < 7);
            x.pos    = (e < 7) ? 3'(e) : 3'd0;
            x.cyc    = cyc;
            x.strict = strict_lat;
            sb.push_back(x);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        stats_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 30) begin
            applyStimulus(1'b0, 4'd0, 7, 1'b1, 1'b0);
            n++;
        end
        checkOutput({name, "_drained"}, sb.size(), 0);
    endtask

    // Monitor: handshake rule, counter model, hold stability and scoreboard pop.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            wc_m      = 0;
            ec_m      = 0;
            hold_prev = 1'b0;
        end else begin
            checkOutput("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
            checkOutput("word_count", int'(word_count), wc_m);
            checkOutput("err_count", int'(err_count), ec_m);
            if (hold_prev) begin
                checkOutput("hold_valid", int'(out_valid), 1);
                checkOutput("hold_data", int'(out_data), int'(prev_data));
                checkOutput("hold_err", int'(out_err), int'(prev_err));
                checkOutput("hold_pos", int'(out_err_pos), int'(prev_pos));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", 1, 0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    checkOutput("out_data", int'(out_data), int'(x.data));
                    checkOutput("out_err", int'(out_err), int'(x.err));
                    checkOutput("out_err_pos", int'(out_err_pos), int'(x.pos));
                    if (x.strict) checkOutput("latency", cyc - x.cyc, 2);
                end
            end
            if (stats_clr) begin
                wc_m = 0;
                ec_m = 0;
            end else if (STATS && out_valid && out_ready) begin
                if (wc_m < CNT_MAX) wc_m++;
                if (out_err && ec_m < CNT_MAX) ec_m++;
            end
            if (!STATS) begin
                wc_m = 0;
                ec_m = 0;
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_err  = out_err;
            prev_pos  = out_err_pos;
        end
    end

    initial begin
        doReset();
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        checkOutput("reset_out_err", int'(out_err), 0);
        checkOutput("reset_out_err_pos", int'(out_err_pos), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_word_count", int'(word_count), 0);

        // Clean words back to back, every data value.
        strict_lat = 1'b1;
        for (int d = 0; d < 16; d++) applyStimulus(1'b1, 4'(d), 7, 1'b1, 1'b0);
        drain("clean");

        // Every single-bit error position for every data value.
        for (int d = 0; d < 16; d++)
            for (int e = 0; e < 7; e++) applyStimulus(1'b1, 4'(d), e, 1'b1, 1'b0);
        drain("single_err");

        // Backpressure: stream in flight, consumer stalls for 5 cycles.
        strict_lat = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i + 9), (i == 1) ? 5 : 7, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'(i), i, 1'b0, 1'b0);
            checkOutput("stall_in_ready", int'(in_ready), 0);
        end
        drain("backpressure");

        // Randomized traffic with random backpressure and occasional clears.
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 19) == 0);
        drain("random");

        // Reset with both stages full.
        applyStimulus(1'b1, 4'd11, 7, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd6, 2, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd3, 7, 1'b0, 1'b0);
        doReset();
        checkOutput("midreset_out_valid", int'(out_valid), 0);
        checkOutput("midreset_word_count", int'(word_count), 0);
        checkOutput("midreset_err_count", int'(err_count), 0);
        strict_lat = 1'b1;
        applyStimulus(1'b1, 4'd11, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd4, 7, 1'b1, 1'b0);
        drain("after_reset");

        // Statistics: saturation with five corrected words.
        applyStimulus(1'b0, 4'd0, 7, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'(i + 2), i, 1'b1, 1'b0);
        drain("stats_sat");
        checkOutput("sat_word_count", int'(word_count), STATS ? 3 : 0);
        checkOutput("sat_err_count", int'(err_count), STATS ? 3 : 0);

        // Clear coinciding with a handshake, then one more delivery.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'(i + 7), 6, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 7, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        checkOutput("clr_word_count", int'(word_count), 0);
        checkOutput("clr_err_count", int'(err_count), 0);
        drain("stats_clr");
        checkOutput("post_clr_word_count", int'(word_count), STATS ? 1 : 0);
        checkOutput("post_clr_err_count", int'(err_count), STATS ? 1 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
